register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 60 ++++++
 tb/tb_register_file.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Sixteen-entry, 32-bit register file with one write port, two combinational
// read ports and an auto-incrementing program counter held in R15.
// Reads of R15 see the PC plus a fixed pipeline offset. Reads of R0-R14
// forward the data being written in the same cycle. R15 is never forwarded.
module register_file #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter logic [31:0] PC_INC      = 32'd4,
   parameter logic [31:0] PC_READ_OFS = 32'd8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        we,
   input  logic [3:0]  wa,
   input  logic [31:0] wd,
   input  logic        pc_en,
   input  logic [3:0]  ra_a,
   input  logic [3:0]  ra_b,
   output logic [31:0] rd_a,
   output logic [31:0] rd_b,
   output logic [31:0] pc
);

   logic [31:0] regs_q [16];
   logic [31:0] regs_d [16];
   logic        pcWrite;
   logic [31:0] pcRead;

   assign pcWrite = we && (wa == 4'd15);
   assign pcRead  = regs_q[15] + PC_READ_OFS;

   // Next-state: an explicit write to R15 takes priority over the increment.
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wa] = wd;
      end
      if (pc_en && !pcWrite) begin
         regs_d[15] = regs_q[15] + PC_INC;
      end
   end

   // State register: reset clears R0-R14 and loads the PC start address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 15; i++) begin
            regs_q[i] <= 32'h0;
         end
         regs_q[15] <= PC_RESET;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_a = (ra_a == 4'd15)          ? pcRead :
                 (we && (wa == ra_a))     ? wd     : regs_q[ra_a];
   assign rd_b = (ra_b == 4'd15)          ? pcRead :
                 (we && (wa == ra_b))     ? wd     : regs_q[ra_b];
   assign pc   = regs_q[15];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by randomized
// traffic, checked against an array model of the architectural registers.
module tb_register_file;

   localparam logic [31:0] PC_RESET    = 32'h0000_0000;
   localparam logic [31:0] PC_INC      = 32'd4;
   localparam logic [31:0] PC_READ_OFS = 32'd8;

   logic        clk;
   logic        reset_n;
   logic        we;
   logic [3:0]  wa;
   logic [31:0] wd;
   logic        pc_en;
   logic [3:0]  ra_a;
   logic [3:0]  ra_b;
   logic [31:0] rd_a;
   logic [31:0] rd_b;
   logic [31:0] pc;

   int compared;
   int mismatched;

   logic [31:0] model [16];

   register_file #(
      .PC_RESET(PC_RESET),
      .PC_INC(PC_INC),
      .PC_READ_OFS(PC_READ_OFS)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .we(we),
      .wa(wa),
      .wd(wd),
      .pc_en(pc_en),
      .ra_a(ra_a),
      .ra_b(ra_b),
      .rd_a(rd_a),
      .rd_b(rd_b),
      .pc(pc)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural view of a read: PC reads carry the offset, in-flight writes
   // to R0-R14 are visible immediately, reset forces the reset contents.
   function automatic logic [31:0] expRead(input logic [3:0] idx);
      if (idx == 4'd15) return model[15] + PC_READ_OFS;
      if (reset_n && we && (wa == idx)) return wd;
      return model[idx];
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 15; i++) model[i] = 32'h0;
      model[15] = PC_RESET;
   endfunction

   // What the registers become at a rising edge.
   function automatic void modelEdge();
      logic [31:0] oldPc;
      if (!reset_n) return;
      oldPc = model[15];
      if (we) model[wa] = wd;
      if (pc_en && !(we && wa == 4'd15)) model[15] = oldPc + PC_INC;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkReads(input string tag);
      checkOutput({tag, " rd_a"}, rd_a, expRead(ra_a));
      checkOutput({tag, " rd_b"}, rd_b, expRead(ra_b));
   endtask

   // Drive one cycle's inputs (called #1 after a rising edge), check the
   // combinational reads, advance through the next edge, then check pc.
   task automatic applyStimulus(input string tag, input logic iWe, input logic [3:0] iWa,
                                input logic [31:0] iWd, input logic iPcEn,
                                input logic [3:0] iRaA, input logic [3:0] iRaB);
      we = iWe; wa = iWa; wd = iWd; pc_en = iPcEn; ra_a = iRaA; ra_b = iRaB;
      #1;
      checkReads({tag, " pre"});
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput({tag, " pc"}, pc, model[15]);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput("reset pc", pc, PC_RESET);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset_n = 1'b0; we = 1'b0; wa = 4'd0; wd = 32'h0; pc_en = 1'b0;
      ra_a = 4'd3; ra_b = 4'd15;
      modelReset();
      #1;
      // Reset contents visible while reset is held.
      checkOutput("inreset rd_a r3", rd_a, 32'h0);
      checkOutput("inreset rd_b r15", rd_b, PC_RESET + PC_READ_OFS);
      checkOutput("inreset pc", pc, PC_RESET);

      // Write and increment requested during reset are ignored.
      we = 1'b1; wa = 4'd2; wd = 32'hCAFE_F00D; pc_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      we = 1'b0; pc_en = 1'b0; ra_a = 4'd2;
      #1;
      checkOutput("reset ignores write", rd_a, 32'h0);
      checkOutput("reset ignores pc_en", pc, PC_RESET);
      reset_n = 1'b1;

      // Basic read after reset.
      ra_a = 4'd3; ra_b = 4'd15;
      #1;
      checkOutput("post reset rd_a", rd_a, 32'h0);
      checkOutput("post reset rd_b", rd_b, 32'h8);
      checkOutput("post reset pc", pc, 32'h0);

      // Forwarding of a write to R5, then the stored value after the edge.
      applyStimulus("w r5", 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd5, 4'd4);
      checkOutput("w r5 bypass", expRead(4'd5), 32'hDEAD_BEEF);
      applyStimulus("r r5", 1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 4'd6);
      checkOutput("r5 stored", rd_a, 32'hDEAD_BEEF);
      checkOutput("r6 untouched", rd_b, 32'h0);

      // PC increments, then a direct PC write that wins over pc_en.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus("pc inc", 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd0);
      we = 1'b0; pc_en = 1'b0; ra_a = 4'd15; #1;
      checkOutput("pc after 3", pc, 32'hC);
      checkOutput("r15 read after 3", rd_a, 32'h14);
      applyStimulus("pc write", 1'b1, 4'd15, 32'h100, 1'b1, 4'd15, 4'd15);
      checkOutput("pc write wins", pc, 32'h100);

      // R15 is not forwarded: read shows old PC plus offset before the edge.
      we = 1'b1; wa = 4'd15; wd = 32'hFFFF_FFFC; pc_en = 1'b0; ra_a = 4'd15; #1;
      checkOutput("no r15 bypass", rd_a, 32'h108);
      applyStimulus("pc max", 1'b1, 4'd15, 32'hFFFF_FFFC, 1'b0, 4'd15, 4'd1);
      applyStimulus("pc wrap", 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd15);
      checkOutput("pc wrapped", pc, 32'h0);
      we = 1'b0; pc_en = 1'b0; #1;
      checkOutput("r15 read wrapped", rd_a, 32'h8);

      // Asynchronous reset between edges clears state immediately.
      applyStimulus("w r7", 1'b1, 4'd7, 32'h1234, 1'b1, 4'd7, 4'd15);
      we = 1'b0; pc_en = 1'b0; ra_a = 4'd7; ra_b = 4'd15; #1;
      checkOutput("r7 before async reset", rd_a, 32'h1234);
      reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async reset r7", rd_a, 32'h0);
      checkOutput("async reset pc", pc, PC_RESET);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Every register written with a distinct value, then all read pairs.
      for (int i = 0; i < 16; i++) begin
         applyStimulus("fill", 1'b1, 4'(i), 32'hA5A5_0000 + 32'(i * 32'h111), 1'b0, 4'(i), 4'(i));
      end
      we = 1'b0; pc_en = 1'b0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ra_a = 4'(a); ra_b = 4'(b); #1;
            checkOutput("all pairs rd_a", rd_a,
                        (a == 15) ? 32'hA5A5_0FFF + PC_READ_OFS : 32'hA5A5_0000 + 32'(a * 32'h111));
            checkOutput("all pairs rd_b", rd_b,
                        (b == 15) ? 32'hA5A5_0FFF + PC_READ_OFS : 32'hA5A5_0000 + 32'(b * 32'h111));
         end
      end
      @(posedge clk); #1;

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
      end
      we = 1'b0; pc_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ra_a = 4'(i); ra_b = 4'(15 - i); #1;
         checkReads("final");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
